// File: rtl/flood_engine.sv
// flood_engine: Flood-It board store, flood-growth FSM and renderer read port.
// Define FLOOD_COUNT_EN to add FLOODED_COUNT and derive WON from the flooded-cell count.
module flood_engine #(
    parameter int MAX_SIZE = 26,
    parameter int COLOR_W  = 3
) (
    input  logic               MASTER_CLOCK,
    input  logic               RESET,
    input  logic               LOAD_WE,
    input  logic [4:0]         LOAD_ROW,
    input  logic [4:0]         LOAD_COL,
    input  logic [COLOR_W-1:0] LOAD_COLOR,
    input  logic               BEGIN_GAME,
    output logic               ACK_BEGIN_GAME,
    input  logic [4:0]         final_SIZE,
    input  logic               COLOR_SEL_SIG,
    input  logic [COLOR_W-1:0] COLOR_SELECTED,
    output logic               CURRENTLY_CHANGING_COLOR,
    input  logic [7:0]         TRIES,
    input  logic [7:0]         TOTAL_TRIES,
    output logic               INITIALIZED,
    output logic               WON,
    output logic               LOST,
    input  logic [4:0]         RD_ROW,
    input  logic [4:0]         RD_COL,
    output logic [COLOR_W-1:0] RD_COLOR
`ifdef FLOOD_COUNT_EN
    ,
    output logic [9:0]         FLOODED_COUNT
`endif
);
    localparam int N  = MAX_SIZE * MAX_SIZE;
    localparam int IW = $clog2(N + MAX_SIZE + 1);
    localparam logic [IW-1:0] L_M    = IW'(MAX_SIZE);
    localparam logic [IW-1:0] L_ONE  = IW'(1);
    localparam logic [IW-1:0] L_LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SWEEP} state_t;

    logic [COLOR_W-1:0] r_color [N];
    logic [N-1:0]       r_flag;
    state_t             r_state;
    logic [4:0]         r_sz;
    logic [4:0]         r_row;
    logic [4:0]         r_col;
    logic [IW-1:0]      r_idx;
    logic [COLOR_W-1:0] r_flood;
    logic [COLOR_W-1:0] r_rd;
    logic               r_changed;
    logic               r_all;
    logic               r_ack;
    logic               r_busy;
    logic               r_init;
    logic               r_won;
    logic               r_lost;
`ifdef FLOOD_COUNT_EN
    logic [9:0]         r_count;
`endif

    function automatic logic [IW-1:0] f_idx(input logic [4:0] row,
                                            input logic [4:0] col);
        return IW'(row) * L_M + IW'(col);
    endfunction

    logic          w_load;
    logic [4:0]    w_sz;
    logic [5:0]    w_row_nx;
    logic [5:0]    w_col_nx;
    logic          w_row_more;
    logic          w_col_more;
    logic          w_nb;
    logic          w_flood;
    logic          w_all_nx;
    logic          w_won;
    logic          w_rd_in;
    logic [IW-1:0] w_rd_idx;

    assign w_load = LOAD_WE && (r_state == S_IDLE)
                 && ({1'b0, LOAD_ROW} < 6'(MAX_SIZE))
                 && ({1'b0, LOAD_COL} < 6'(MAX_SIZE));
    assign w_sz = ({1'b0, final_SIZE} > 6'(MAX_SIZE)) ? 5'(MAX_SIZE)
                                                      : final_SIZE;

    assign w_row_nx   = {1'b0, r_row} + 6'd1;
    assign w_col_nx   = {1'b0, r_col} + 6'd1;
    assign w_row_more = w_row_nx < {1'b0, r_sz};
    assign w_col_more = w_col_nx < {1'b0, r_sz};

    // Off-edge neighbours are masked, so wrapped indices never contribute.
    always_comb begin
        w_nb = 1'b0;
        if ((r_row != 5'd0) && r_flag[r_idx - L_M]) w_nb = 1'b1;
        if (w_row_more && r_flag[r_idx + L_M])      w_nb = 1'b1;
        if ((r_col != 5'd0) && r_flag[r_idx - L_ONE]) w_nb = 1'b1;
        if (w_col_more && r_flag[r_idx + L_ONE])    w_nb = 1'b1;
    end

    assign w_flood  = !r_flag[r_idx] && (r_color[r_idx] == r_flood) && w_nb;
    assign w_all_nx = r_all && (r_flag[r_idx] || w_flood);
`ifdef FLOOD_COUNT_EN
    assign w_won = (r_count == 10'(r_sz) * 10'(r_sz));
`else
    assign w_won = w_all_nx;
`endif

    assign w_rd_in  = (RD_ROW < r_sz) && (RD_COL < r_sz);
    assign w_rd_idx = f_idx(RD_ROW, RD_COL);

    always_ff @(posedge MASTER_CLOCK) begin
        if (w_load) r_color[f_idx(LOAD_ROW, LOAD_COL)] <= LOAD_COLOR;
    end

    always_ff @(posedge MASTER_CLOCK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_flag    <= '0;
            r_sz      <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_idx     <= '0;
            r_flood   <= '0;
            r_rd      <= '0;
            r_changed <= 1'b0;
            r_all     <= 1'b1;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_init    <= 1'b0;
            r_won     <= 1'b0;
            r_lost    <= 1'b0;
`ifdef FLOOD_COUNT_EN
            r_count   <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_rd  <= w_rd_in ? (r_flag[w_rd_idx] ? r_flood : r_color[w_rd_idx])
                             : '0;
            unique case (r_state)
                S_IDLE: begin
                    if (BEGIN_GAME) begin
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_sz    <= w_sz;
                        r_idx   <= '0;
                        r_state <= S_CLEAR;
                    end else if (r_busy) begin
                        // Ended game: one-cycle handshake only, no sweep.
                        r_busy <= 1'b0;
                    end else if (COLOR_SEL_SIG) begin
                        r_busy <= 1'b1;
                        if (!(r_won || r_lost)) begin
                            r_flood   <= COLOR_SELECTED;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_idx     <= '0;
                            r_changed <= 1'b0;
                            r_all     <= 1'b1;
                            r_state   <= S_SWEEP;
                        end
                    end
                end
                S_CLEAR: begin
                    r_flag[r_idx] <= 1'b0;
                    if (r_idx == L_LAST) begin
                        r_flag[0] <= 1'b1;
                        r_flood   <= r_color[0];
                        r_won     <= 1'b0;
                        r_lost    <= 1'b0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_idx     <= '0;
                        r_changed <= 1'b0;
                        r_all     <= 1'b1;
`ifdef FLOOD_COUNT_EN
                        r_count   <= 10'd1;
`endif
                        r_state   <= S_SWEEP;
                    end else begin
                        r_idx <= r_idx + L_ONE;
                    end
                end
                S_SWEEP: begin
                    if (w_flood) begin
                        r_flag[r_idx] <= 1'b1;
                        r_changed     <= 1'b1;
`ifdef FLOOD_COUNT_EN
                        r_count       <= r_count + 10'd1;
`endif
                    end
                    r_all <= w_all_nx;
                    if (w_col_more) begin
                        r_col <= r_col + 5'd1;
                        r_idx <= r_idx + L_ONE;
                    end else if (w_row_more) begin
                        r_row <= w_row_nx[4:0];
                        r_col <= '0;
                        r_idx <= f_idx(w_row_nx[4:0], 5'd0);
                    end else if (r_changed || w_flood) begin
                        r_row     <= '0;
                        r_col     <= '0;
                        r_idx     <= '0;
                        r_changed <= 1'b0;
                        r_all     <= 1'b1;
                    end else begin
                        r_won   <= w_won;
                        r_lost  <= !w_won && (TRIES >= TOTAL_TRIES);
                        r_init  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ACK_BEGIN_GAME           = r_ack;
    assign CURRENTLY_CHANGING_COLOR = r_busy;
    assign INITIALIZED              = r_init;
    assign WON                      = r_won;
    assign LOST                     = r_lost;
    assign RD_COLOR                 = r_rd;
`ifdef FLOOD_COUNT_EN
    assign FLOODED_COUNT            = r_count;
`endif

endmodule

// File: tb/tb_flood_engine.sv
// tb_flood_engine: scenario tasks with a reference flood model and a
// read-port scoreboard for flood_engine.
module tb_flood_engine;
    localparam int M = 26;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       LOAD_WE = 1'b0;
    logic [4:0] LOAD_ROW = '0;
    logic [4:0] LOAD_COL = '0;
    logic [2:0] LOAD_COLOR = '0;
    logic       BEGIN_GAME = 1'b0;
    logic       ACK_BEGIN_GAME;
    logic [4:0] final_SIZE = '0;
    logic       COLOR_SEL_SIG = 1'b0;
    logic [2:0] COLOR_SELECTED = '0;
    logic       CURRENTLY_CHANGING_COLOR;
    logic [7:0] TRIES = '0;
    logic [7:0] TOTAL_TRIES = 8'd10;
    logic       INITIALIZED;
    logic       WON;
    logic       LOST;
    logic [4:0] RD_ROW = '0;
    logic [4:0] RD_COL = '0;
    logic [2:0] RD_COLOR;
`ifdef FLOOD_COUNT_EN
    logic [9:0] FLOODED_COUNT;
`endif

    always #5 clk = ~clk;

    flood_engine dut (
        .MASTER_CLOCK(clk),
        .RESET(RESET),
        .LOAD_WE(LOAD_WE),
        .LOAD_ROW(LOAD_ROW),
        .LOAD_COL(LOAD_COL),
        .LOAD_COLOR(LOAD_COLOR),
        .BEGIN_GAME(BEGIN_GAME),
        .ACK_BEGIN_GAME(ACK_BEGIN_GAME),
        .final_SIZE(final_SIZE),
        .COLOR_SEL_SIG(COLOR_SEL_SIG),
        .COLOR_SELECTED(COLOR_SELECTED),
        .CURRENTLY_CHANGING_COLOR(CURRENTLY_CHANGING_COLOR),
        .TRIES(TRIES),
        .TOTAL_TRIES(TOTAL_TRIES),
        .INITIALIZED(INITIALIZED),
        .WON(WON),
        .LOST(LOST),
        .RD_ROW(RD_ROW),
        .RD_COL(RD_COL),
        .RD_COLOR(RD_COLOR)
`ifdef FLOOD_COUNT_EN
        ,
        .FLOODED_COUNT(FLOODED_COUNT)
`endif
    );

    int checks = 0;
    int failures = 0;

    int bcol [M][M];
    bit bflag [M][M];
    int bfc = 0;
    int bsz = 0;

    int exp_q [$];
    int got_q [$];
    int loc_q [$];

    function automatic void m_grow();
        bit ch = 1'b1;
        while (ch) begin
            ch = 1'b0;
            for (int r = 0; r < bsz; r++)
                for (int c = 0; c < bsz; c++)
                    if (!bflag[r][c] && bcol[r][c] == bfc &&
                        ((r > 0 && bflag[r-1][c]) ||
                         (r + 1 < bsz && bflag[r+1][c]) ||
                         (c > 0 && bflag[r][c-1]) ||
                         (c + 1 < bsz && bflag[r][c+1]))) begin
                        bflag[r][c] = 1'b1;
                        ch = 1'b1;
                    end
        end
    endfunction

    function automatic void m_start();
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                bflag[r][c] = 1'b0;
        bflag[0][0] = 1'b1;
        bfc = bcol[0][0];
        m_grow();
    endfunction

    function automatic logic m_won();
        for (int r = 0; r < bsz; r++)
            for (int c = 0; c < bsz; c++)
                if (!bflag[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int exp_rd(input int r, input int c);
        if (r >= bsz || c >= bsz) return 0;
        return bflag[r][c] ? bfc : bcol[r][c];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ccc(input logic lvl, input int budget, output int n);
        n = 0;
        while (CURRENTLY_CHANGING_COLOR !== lvl && n < budget) begin
            tick();
            n++;
        end
        if (CURRENTLY_CHANGING_COLOR !== lvl) n = -1;
    endtask

    task automatic load_board(input int n);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                LOAD_WE    = 1'b1;
                LOAD_ROW   = 5'(r);
                LOAD_COL   = 5'(c);
                LOAD_COLOR = 3'(bcol[r][c]);
                tick();
            end
        LOAD_WE = 1'b0;
    endtask

    task automatic read_board();
        for (int r = 0; r <= bsz; r++)
            for (int c = 0; c <= bsz; c++) begin
                RD_ROW = 5'(r);
                RD_COL = 5'(c);
                exp_q.push_back(exp_rd(r, c));
                loc_q.push_back(r * 100 + c);
                tick();
                got_q.push_back(int'(RD_COLOR));
            end
    endtask

    task automatic start_game(input int n, output int ack_cyc,
                              output logic ack2, output int done);
        final_SIZE = 5'(n);
        BEGIN_GAME = 1'b1;
        ack_cyc = 0;
        do begin
            tick();
            ack_cyc++;
        end while (ACK_BEGIN_GAME !== 1'b1 && ack_cyc < 8);
        if (ACK_BEGIN_GAME !== 1'b1) ack_cyc = -1;
        BEGIN_GAME = 1'b0;
        tick();
        ack2 = ACK_BEGIN_GAME;
        wait_ccc(1'b0, 20000, done);
        bsz = n;
        m_start();
    endtask

    task automatic select_color(input int c, output int rise, output int done);
        COLOR_SELECTED = 3'(c);
        COLOR_SEL_SIG = 1'b1;
        rise = 0;
        do begin
            tick();
            rise++;
        end while (CURRENTLY_CHANGING_COLOR !== 1'b1 && rise < 4);
        if (CURRENTLY_CHANGING_COLOR !== 1'b1) rise = -1;
        COLOR_SEL_SIG = 1'b0;
        wait_ccc(1'b0, 20000, done);
    endtask

    task automatic test_reset();
        int pts [4] = '{0, 305, 2525, 3131};
        int e, g, l;
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, INITIALIZED, WON, LOST} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=00000",
                     {ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, INITIALIZED, WON, LOST});
        end
        RESET = 1'b0;
        bsz = 0;
        foreach (pts[i]) begin
            RD_ROW = 5'(pts[i] / 100);
            RD_COL = 5'(pts[i] % 100);
            exp_q.push_back(0);
            loc_q.push_back(pts[i]);
            tick();
            got_q.push_back(int'(RD_COLOR));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            l = loc_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_rd r%0d c%0d got=%0d exp=%0d", l / 100, l % 100, g, e);
            end
        end
    endtask

    task automatic test_small_win();
        int ack_cyc, done, e, g, l;
        logic ack2;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                bcol[r][c] = 0;
        load_board(2);
        start_game(2, ack_cyc, ack2, done);
        checks++;
        if (ack_cyc !== 1) begin
            failures++;
            $display("FAIL small_ack_lat got=%0d exp=1", ack_cyc);
        end
        checks++;
        if (ack2 !== 1'b0) begin
            failures++;
            $display("FAIL small_ack_width got=%b exp=0", ack2);
        end
        checks++;
        if (done < 0) begin
            failures++;
            $display("FAIL small_done got=timeout exp=finish");
        end
        checks++;
        if ({INITIALIZED, WON, LOST} !== {1'b1, m_won(), 1'b0}) begin
            failures++;
            $display("FAIL small_flags got=%b exp=%b", {INITIALIZED, WON, LOST},
                     {1'b1, m_won(), 1'b0});
        end
        read_board();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            l = loc_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL small_rd r%0d c%0d got=%0d exp=%0d", l / 100, l % 100, g, e);
            end
        end
    endtask

    task automatic test_color_change();
        int ack_cyc, done, rise, e, g, l;
        logic ack2;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                bcol[r][c] = 2;
        bcol[0][0] = 1;
        load_board(6);
        start_game(6, ack_cyc, ack2, done);
        checks++;
        if ({INITIALIZED, WON} !== {1'b1, m_won()}) begin
            failures++;
            $display("FAIL chg_start got=%b exp=%b", {INITIALIZED, WON}, {1'b1, m_won()});
        end
        select_color(2, rise, done);
        bfc = 2;
        m_grow();
        checks++;
        if (rise !== 1) begin
            failures++;
            $display("FAIL chg_rise got=%0d exp=1", rise);
        end
        checks++;
        if (done < 0) begin
            failures++;
            $display("FAIL chg_fall got=timeout exp=fall");
        end
        checks++;
        if ({WON, LOST} !== {m_won(), 1'b0}) begin
            failures++;
            $display("FAIL chg_won got=%b exp=%b", {WON, LOST}, {m_won(), 1'b0});
        end
        read_board();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            l = loc_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL chg_rd r%0d c%0d got=%0d exp=%0d", l / 100, l % 100, g, e);
            end
        end
    endtask

    task automatic test_lost();
        int ack_cyc, done, rise, e, g, l;
        logic ack2;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                bcol[r][c] = (r + c) % 2;
        TRIES = 8'd0;
        TOTAL_TRIES = 8'd1;
        load_board(6);
        start_game(6, ack_cyc, ack2, done);
        checks++;
        if ({WON, LOST} !== 2'b00) begin
            failures++;
            $display("FAIL lost_start got=%b exp=00", {WON, LOST});
        end
        TRIES = 8'd1;
        select_color(1, rise, done);
        bfc = 1;
        m_grow();
        checks++;
        if ({WON, LOST} !== {m_won(), !m_won()}) begin
            failures++;
            $display("FAIL lost_flags got=%b exp=%b", {WON, LOST}, {m_won(), !m_won()});
        end
        select_color(0, rise, done);
        checks++;
        if (rise < 1 || rise > 2) begin
            failures++;
            $display("FAIL lost_hs_rise got=%0d exp=1..2", rise);
        end
        checks++;
        if (done !== 1) begin
            failures++;
            $display("FAIL lost_hs_fall got=%0d exp=1", done);
        end
        read_board();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            l = loc_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL lost_rd r%0d c%0d got=%0d exp=%0d", l / 100, l % 100, g, e);
            end
        end
        TRIES = 8'd0;
        TOTAL_TRIES = 8'd10;
    endtask

    task automatic test_serpentine();
        int ack_cyc, done, rise, e, g, l;
        logic ack2;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                bcol[r][c] = (r % 2 == 0) ? 3 : 4;
        bcol[1][9] = 3;
        bcol[3][0] = 3;
        bcol[5][9] = 3;
        bcol[7][0] = 3;
        bcol[9][9] = 3;
        bcol[0][0] = 5;
        load_board(10);
        start_game(10, ack_cyc, ack2, done);
        select_color(3, rise, done);
        bfc = 3;
        m_grow();
        checks++;
        if (done <= 200) begin
            failures++;
            $display("FAIL serp_passes got=%0d exp=>200", done);
        end
        checks++;
        if ({WON, LOST} !== 2'b00) begin
            failures++;
            $display("FAIL serp_flags got=%b exp=00", {WON, LOST});
        end
        // Recolour to an absent colour so flagged channel cells become visible.
        select_color(6, rise, done);
        bfc = 6;
        m_grow();
        read_board();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            l = loc_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL serp_rd r%0d c%0d got=%0d exp=%0d", l / 100, l % 100, g, e);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ack_cyc, done, rise, e, g, l;
        logic ack2;
        COLOR_SELECTED = 3'd4;
        COLOR_SEL_SIG = 1'b1;
        rise = 0;
        do begin
            tick();
            rise++;
        end while (CURRENTLY_CHANGING_COLOR !== 1'b1 && rise < 4);
        COLOR_SEL_SIG = 1'b0;
        repeat (30) tick();
        LOAD_WE = 1'b1;
        LOAD_ROW = 5'd1;
        LOAD_COL = 5'd0;
        LOAD_COLOR = 3'd7;
        tick();
        LOAD_WE = 1'b0;
        checks++;
        if (CURRENTLY_CHANGING_COLOR !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=1", CURRENTLY_CHANGING_COLOR);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bsz = 0;
        checks++;
        if ({ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, INITIALIZED, WON, LOST} !== 5'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=00000",
                     {ACK_BEGIN_GAME, CURRENTLY_CHANGING_COLOR, INITIALIZED, WON, LOST});
        end
        start_game(10, ack_cyc, ack2, done);
        checks++;
        if (ack_cyc !== 1) begin
            failures++;
            $display("FAIL mid_idle_ack got=%0d exp=1", ack_cyc);
        end
        checks++;
        if ({INITIALIZED, WON} !== {1'b1, m_won()}) begin
            failures++;
            $display("FAIL mid_restart got=%b exp=%b", {INITIALIZED, WON}, {1'b1, m_won()});
        end
        read_board();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            l = loc_q.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL mid_rd r%0d c%0d got=%0d exp=%0d", l / 100, l % 100, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_win();
        test_color_change();
        test_lost();
        test_serpentine();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
